// File: rtl/fft16_input_sequencer.sv
// Front-end of the 16-point FFT: captures one natural-order frame of samples and
// replays it in 4-bit bit-reversed order, tagging each word with its demux lane.
module fft16_input_sequencer #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WORD_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] out_data,
   output logic [1:0]           out_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 group_done,
   output logic                 frame_done
);
   typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

   state_t               state_reg;
   logic [WORD_SIZE-1:0] sample_buf [16];
   logic [3:0]           wr_cnt_reg;
   logic [3:0]           rd_cnt_reg;
   logic [3:0]           rd_cnt_next;
   logic [3:0]           rd_addr_next;
   logic                 in_ready_reg;
   logic                 out_valid_reg;
   logic [1:0]           out_sel_reg;
   logic [WORD_SIZE-1:0] out_data_reg;
   logic                 group_done_reg;
   logic                 frame_done_reg;
   logic                 wr_en;

   assign rd_cnt_next = rd_cnt_reg + 4'd1;

   // Buffer address of the word that follows the current one: bit-reversed count.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bitrev
         assign rd_addr_next[gi] = rd_cnt_next[3 - gi];
      end
   endgenerate

   assign wr_en = (state_reg == LOAD) && in_ready_reg && in_valid;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         sample_buf[wr_cnt_reg] <= in_data;
      end
   end

   // Output word is prefetched one accept ahead so out_data never depends on out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= LOAD;
         wr_cnt_reg     <= 4'd0;
         rd_cnt_reg     <= 4'd0;
         in_ready_reg   <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_sel_reg    <= 2'd0;
         out_data_reg   <= '0;
         group_done_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         group_done_reg <= 1'b0;
         frame_done_reg <= 1'b0;
         case (state_reg)
            LOAD: begin
               in_ready_reg <= 1'b1;
               if (wr_en) begin
                  wr_cnt_reg <= wr_cnt_reg + 4'd1;
                  if (wr_cnt_reg == 4'd15) begin
                     state_reg     <= DRAIN;
                     in_ready_reg  <= 1'b0;
                     out_valid_reg <= 1'b1;
                     out_sel_reg   <= 2'd0;
                     out_data_reg  <= sample_buf[4'd0];
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  rd_cnt_reg   <= rd_cnt_next;
                  out_sel_reg  <= rd_cnt_next[1:0];
                  out_data_reg <= sample_buf[rd_addr_next];
                  if (rd_cnt_reg[1:0] == 2'd3) begin
                     group_done_reg <= 1'b1;
                  end
                  if (rd_cnt_reg == 4'd15) begin
                     frame_done_reg <= 1'b1;
                     state_reg      <= LOAD;
                     in_ready_reg   <= 1'b1;
                     out_valid_reg  <= 1'b0;
                     out_sel_reg    <= 2'd0;
                     out_data_reg   <= '0;
                  end
               end
            end
            default: state_reg <= LOAD;
         endcase
      end
   end

   assign in_ready   = in_ready_reg;
   assign out_valid  = out_valid_reg;
   assign out_sel    = out_sel_reg;
   assign out_data   = out_data_reg;
   assign group_done = group_done_reg;
   assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_fft16_input_sequencer.sv
// Randomized bench for fft16_input_sequencer: a frame-level model predicts every
// output each cycle, and literal tables pin the bit-reversed order and timing.
module tb_fft16_input_sequencer;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic [1:0]   out_sel;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         group_done;
   logic         frame_done;

   int total = 0;
   int bad = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   fft16_input_sequencer #(.WORD_SIZE(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
      .group_done(group_done), .frame_done(frame_done)
   );

   // Frame-level model: a frame is collected, then emitted in bit-reversed index order.
   logic [W-1:0] m_frame [16];
   bit m_loading = 1'b1;
   int m_loaded = 0;
   int m_sent = 0;
   bit m_in_ready = 1'b0;
   bit m_gd = 1'b0;
   bit m_fd = 1'b0;

   function automatic int brev(input int k);
      return ((k & 1) << 3) | ((k & 2) << 1) | ((k >> 1) & 2) | ((k >> 3) & 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_loading = 1'b1; m_loaded = 0; m_sent = 0;
         m_in_ready = 1'b0; m_gd = 1'b0; m_fd = 1'b0;
      end else begin
         m_gd = 1'b0;
         m_fd = 1'b0;
         if (m_loading) begin
            if (m_in_ready && in_valid) begin
               m_frame[m_loaded] = in_data;
               m_loaded++;
               if (m_loaded == 16) begin
                  m_loading = 1'b0; m_sent = 0; m_in_ready = 1'b0;
               end
            end else begin
               m_in_ready = 1'b1;
            end
         end else if (out_ready) begin
            if (m_sent % 4 == 3) m_gd = 1'b1;
            m_sent++;
            if (m_sent == 16) begin
               m_fd = 1'b1; m_loading = 1'b1; m_loaded = 0; m_in_ready = 1'b1;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (check_en) begin
         chk("in_ready", 32'(in_ready), 32'(m_in_ready));
         chk("out_valid", 32'(out_valid), 32'(!m_loading));
         chk("out_sel", 32'(out_sel), m_loading ? 32'd0 : 32'(m_sent % 4));
         chk("out_data", 32'(out_data), m_loading ? 32'd0 : 32'(m_frame[brev(m_sent)]));
         chk("group_done", 32'(group_done), 32'(m_gd));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
      end
   end

   logic [W-1:0] rec_data [64];
   logic [1:0]   rec_sel [64];
   int rec_n, gd_n, fd_n, fd_c, first_c;
   bit fd_ready;
   int lit_order [16];

   // rst_mode 1: one-cycle reset after rst_at samples accepted; 2: after rst_at words drained.
   task automatic run(input int limit, input int pv, input int pr, input logic [W-1:0] base,
                      input int dead_at, input int rst_mode, input int rst_at, input string tag);
      int idx = 0;
      int c = 0;
      bit last_acc = 1'b0;
      bit fired = 1'b0;
      rec_n = 0; gd_n = 0; fd_n = 0; fd_c = -1; first_c = -1; fd_ready = 1'b0;
      forever begin
         @(negedge clk);
         c++;
         if (!rst_n) begin
            chk({tag, "_rst_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_rst_out_data"}, 32'(out_data), 32'd0);
            chk({tag, "_rst_group_done"}, 32'(group_done), 32'd0);
            chk({tag, "_rst_frame_done"}, 32'(frame_done), 32'd0);
            rst_n = 1'b1;
            idx = 0; rec_n = 0; gd_n = 0; fd_n = 0; fd_c = -1; first_c = -1;
         end else if (last_acc) begin
            idx++;
         end
         last_acc = 1'b0;
         if (group_done) gd_n++;
         if (frame_done) begin
            fd_n++; fd_c = c; fd_ready = in_ready;
         end
         if (c > 2000) begin
            total++; bad++;
            $display("FAIL %s_timeout: got cycle %0d want done by 2000", tag, c);
            in_valid = 1'b0; out_ready = 1'b0;
            break;
         end
         if (idx == limit && m_loading && m_loaded == 0) begin
            in_valid = 1'b0; out_ready = 1'b0;
            break;
         end
         if (!fired && ((rst_mode == 1 && idx == rst_at) || (rst_mode == 2 && rec_n == rst_at))) begin
            fired = 1'b1; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
         end else begin
            in_valid = (idx < limit) && ($urandom_range(99) < pv);
            in_data = (idx == dead_at) ? 16'hDEAD : base + W'(idx);
            out_ready = ($urandom_range(99) < pr);
            last_acc = in_valid && in_ready;
            if (last_acc && first_c < 0) first_c = c;
            if (out_valid && out_ready && rec_n < 64) begin
               $display("%s word %0d sel=%0d data=%h", tag, rec_n, out_sel, out_data);
               rec_data[rec_n] = out_data;
               rec_sel[rec_n] = out_sel;
               rec_n++;
            end
         end
      end
   endtask

   task automatic check_frame(input string tag, input logic [W-1:0] base, input int f);
      for (int k = 0; k < 16; k++) begin
         chk({tag, "_order"}, 32'(rec_data[f * 16 + k]), 32'(base + W'(f * 16 + lit_order[k])));
         chk({tag, "_sel"}, 32'(rec_sel[f * 16 + k]), 32'(k % 4));
      end
   endtask

   initial begin
      lit_order = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      repeat (2) @(posedge clk);
      check_en = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_sel", 32'(out_sel), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_pulses", 32'({group_done, frame_done}), 32'd0);
      rst_n = 1'b1;

      run(16, 100, 100, 16'h0000, -1, 0, 0, "basic");
      check_frame("basic", 16'h0000, 0);
      chk("basic_groups", 32'(gd_n), 32'd4);
      chk("basic_frames", 32'(fd_n), 32'd1);
      chk("basic_latency", 32'(fd_c - first_c), 32'd32);
      chk("basic_ready_at_done", 32'(fd_ready), 32'd1);

      run(16, 50, 50, 16'h1000, -1, 0, 0, "gaps");
      check_frame("gaps", 16'h1000, 0);
      chk("gaps_groups", 32'(gd_n), 32'd4);
      chk("gaps_frames", 32'(fd_n), 32'd1);

      run(48, 100, 100, 16'h3000, -1, 0, 0, "b2b");
      for (int f = 0; f < 3; f++) check_frame("b2b", 16'h3000, f);
      chk("b2b_groups", 32'(gd_n), 32'd12);
      chk("b2b_frames", 32'(fd_n), 32'd3);
      chk("b2b_cycles", 32'(fd_c - first_c), 32'd96);

      run(32, 100, 70, 16'h2000, 16, 0, 0, "holdoff");
      check_frame("holdoff", 16'h2000, 0);
      chk("holdoff_dead_first", 32'(rec_data[16]), 32'h0000DEAD);
      chk("holdoff_next", 32'(rec_data[17]), 32'h00002018);

      run(16, 100, 100, 16'h4000, -1, 1, 9, "rst_load");
      check_frame("rst_load", 16'h4000, 0);
      chk("rst_load_frames", 32'(fd_n), 32'd1);

      run(16, 100, 100, 16'h5000, -1, 2, 6, "rst_drain");
      check_frame("rst_drain", 16'h5000, 0);
      chk("rst_drain_frames", 32'(fd_n), 32'd1);

      run(48, 60, 40, 16'h6000, -1, 0, 0, "random");
      for (int f = 0; f < 3; f++) check_frame("random", 16'h6000, f);
      chk("random_frames", 32'(fd_n), 32'd3);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish by 1ms");
      $fatal(1);
   end
endmodule
